// File: rtl/demux_1_8_deserializer.sv
// demux_1_8_deserializer
// Rebuilds 8-bit words from a serial bit stream. The transmit side walks a
// 3-bit select from 0 to 7, one bit per cycle. Each accepted bit is steered
// into one accumulator slot chosen by the slot index. A completed word is
// held in a registered output with a valid/ready handshake.
//
// Parameters:
//   LSB_FIRST    1: the bit taken at index k lands in slot k.
//                0: the bit taken at index k lands in slot 7-k.
// Ports:
//   clock        system clock; all state updates on the rising edge
//   reset        asynchronous active-low reset
//   sync         frame start; a bit presented in this cycle is index 0
//   in_valid     in_bit is valid this cycle
//   in_bit       serial data bit
//   in_ready     the block can accept in_bit this cycle (combinational)
//   out_valid    out_data holds an unconsumed word
//   out_ready    the consumer takes out_data this cycle
//   out_data     assembled word
//   index        current slot index (debug)
//   partial_drop one-cycle pulse: sync discarded a partially built word
module demux_1_8_deserializer #(
  parameter int LSB_FIRST = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       sync,
  input  logic       in_valid,
  input  logic       in_bit,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic [2:0] index,
  output logic       partial_drop
);

  logic [7:0] acc;
  logic [2:0] eidx;
  logic [2:0] slot;
  logic       accept;
  logic       complete;
  logic [7:0] merged;

  always_comb begin
    eidx     = sync ? 3'd0 : index;
    // Only the eighth bit needs the holding register, so only it stalls.
    in_ready = !((eidx == 3'd7) && out_valid && !out_ready);
    accept   = in_valid && in_ready;
    complete = accept && (eidx == 3'd7);
    slot     = (LSB_FIRST != 0) ? eidx : (3'd7 - eidx);
    // A sync restarts the word, so the new bit merges into a cleared base.
    merged       = sync ? '0 : acc;
    merged[slot] = in_bit;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      index        <= '0;
      acc          <= '0;
      out_data     <= '0;
      out_valid    <= 1'b0;
      partial_drop <= 1'b0;
    end else begin
      partial_drop <= sync && (index != 3'd0);

      if (accept) begin
        index <= eidx + 3'd1;
        if (complete) begin
          out_data <= merged;
          acc      <= '0;
        end else begin
          acc <= merged;
        end
      end else if (sync) begin
        index <= '0;
        acc   <= '0;
      end

      // Completion wins over a simultaneous transfer: back-to-back words
      // keep out_valid high with no bubble.
      if (complete) begin
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/demux_1_8_deserializer.md
Name: demux_1_8_deserializer

Overview:
- Receive-side counterpart of the 8:1 bit-select path. The transmit side walks a 3-bit select from 0 to 7 to put one bit per cycle on a serial line; this block rebuilds each 8-bit word.
- Each accepted serial bit is routed into one slot of an 8-bit accumulator, chosen by an internal 3-bit index.
- Each completed word is presented on a registered output with a valid/ready handshake.
- Sits between serial datapath links and parallel 8-bit consumers in the processor.

Parameters:
- LSB_FIRST, default 1. 1: the bit taken at index k goes to slot k. 0: it goes to slot 7-k.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- sync  input  1  frame start; the bit presented this cycle, if any, is index 0.
- in_valid  input  1  in_bit is valid this cycle.
- in_bit  input  1  serial data bit.
- in_ready  output  1  the block can accept in_bit this cycle (combinational).
- out_valid  output  1  out_data holds an unconsumed word.
- out_ready  input  1  consumer takes out_data this cycle.
- out_data  output  8  assembled word.
- index  output  3  current slot index, for debug.
- partial_drop  output  1  one-cycle pulse: sync discarded a partially assembled word.

Behaviour:
- Reset (reset=0, asynchronous): clears index, accumulator acc, out_data, out_valid and partial_drop to 0. in_ready evaluates to 1 while reset is held.
- Effective index: eidx = sync ? 0 : index.
- in_ready = NOT(eidx==7 AND out_valid AND NOT out_ready).
  - Stalls only the eighth bit, and only when the holding register is full and not draining.
- Accept condition: in_valid AND in_ready.
- On accept:
  - Write in_bit to acc at slot eidx (LSB_FIRST=1) or 7-eidx (LSB_FIRST=0).
  - index <= eidx+1, modulo 8 (7 wraps to 0).
- Word completion (accept with eidx==7):
  - out_data <= acc with the new bit merged in, same edge.
  - out_valid <= 1; the word is visible the cycle after the eighth bit is accepted.
  - acc is cleared.
- Output handshake:
  - The word transfers on a cycle with out_valid AND out_ready.
  - Completion plus transfer in the same cycle: out_valid stays 1, out_data takes the new word (back-to-back, no bubble).
  - Transfer without completion: out_valid <= 0 and out_data holds its value.
  - While out_valid=1 and out_ready=0, out_data is stable.
- sync:
  - Synchronous.
  - sync with no accept: index <= 0, acc <= 0.
  - sync with accept: the bit lands in slot 0 (or 7 when LSB_FIRST=0), index <= 1, all other slots cleared.
  - partial_drop <= 1 for one cycle whenever sync is sampled while index != 0.
  - sync never affects out_valid or out_data.
- in_valid=0: no change to index or acc.
- Reset mid-word or with a pending output: all state is lost immediately; no word is emitted afterwards.

Test Plan:
- LSB_FIRST=1: out_ready=1, sync on the first bit, bits 1,0,1,0,0,1,0,1 on 8 consecutive cycles -> out_valid=1 for exactly one cycle, on the cycle after the 8th bit, with out_data=0xA5; index back to 0.
- LSB_FIRST=0: sequence 1,0,0,0,0,0,0,0 -> out_data=0x80. The same sequence with LSB_FIRST=1 -> 0x01.
- Backpressure:
  - out_ready=0; stream 0x3C then 0xC3 continuously.
  - in_ready drops to 0 while the 8th bit of 0xC3 is presented; out_data holds 0x3C.
  - Raise out_ready for one cycle -> 0x3C transfers, the 8th bit is accepted the same cycle, next cycle out_data=0xC3 and out_valid=1.
  - No bit is lost or duplicated.
- Sync resynchronisation:
  - Send 3 bits, then sync with a bit on the 4th cycle -> partial_drop pulses once, index=1.
  - The following 7 bits complete a word built only from the post-sync bits (e.g. 0xFF when all are 1); no word is produced from the first 3 bits.
- Wrap and streaming: 4 back-to-back words 0x00,0xFF,0x55,0xAA with out_ready=1 -> 4 out_valid pulses one word every 8 cycles, correct values in order, in_ready constantly 1.
- Reset mid-operation:
  - Assert reset after 5 bits, and separately while out_valid=1 with out_ready=0 -> out_valid, out_data, index and partial_drop are 0 asynchronously.
  - After release, a fresh 8-bit sequence 0x5A produces exactly 0x5A.
